operand_shifter_pipe: RTL
=========================

// Module: operand_shifter_pipe
// PURPOSE
//  Parametrised, pipelined ARM operand-2 barrel shifter with valid/ready handshake, tag pass-through and flush.
//  Generalises the decode-stage combinational shifter: any power-of-two data width, configurable register depth.
//  Elastic: stalls back-propagate stage by stage rather than through one global stall.
//  Sits between register-read and execute; also used by load/store address offset generation.
// PARAMETERS
//  WIDTH   32  data width; power of two, 8..64
//  STAGES  2   register stages from accept to result, 1..4
//  TAG_W   4   width of opaque sideband tag carried with each operation
// PORTS
//  clk        in   1       clock; all state updates on rising edge
//  rst        in   1       synchronous reset, active high
//  flush      in   1       discard every in-flight operation
//  in_valid   in   1       input operation present
//  in_ready   out  1       block accepts input this cycle
//  in_oper    in   WIDTH   operand to shift
//  in_amt     in   8       shift amount (register-specified semantics; caller maps imm LSR/ASR #0 to WIDTH)
//  in_type    in   2       00 LSL, 01 LSR, 10 ASR, 11 ROR
//  in_rrx     in   1       1 = RRX; overrides in_type and in_amt
//  in_carry   in   1       incoming C flag
//  in_tag     in   TAG_W   sideband, returned unchanged with result
//  out_valid  out  1       result present
//  out_ready  in   1       consumer takes result this cycle
//  out_res    out  WIDTH   shifted value
//  out_carry  out  1       shifter carry-out
//  out_tag    out  TAG_W   tag of this result
// BEHAVIOUR
//  - Reset: all stage valids, out_valid, out_res, out_carry, out_tag = 0; in_ready = 1 from the first cycle after reset.
//  - Transfer on in_valid&in_ready (accept) and out_valid&out_ready (retire); results leave in accept order.
//  - Latency: accepted at edge N -> out_valid at edge N+STAGES when no backpressure; throughput 1/cycle.
//  - Stage k loads when empty or when stage k+1 loads/retires; in_ready = stage 0 can load (combinational from out_ready).
//  - While out_valid & !out_ready, out_res/out_carry/out_tag are held stable; no op is lost or duplicated.
//  - Arithmetic (W=WIDTH, a=in_amt, o=in_oper, c=in_carry):
//    LSL: a=0 -> o,c; 0<a<W -> o<<a, o[W-a]; a=W -> 0, o[0]; a>W -> 0, 0
//    LSR: a=0 -> o,c; 0<a<W -> o>>a, o[a-1]; a=W -> 0, o[W-1]; a>W -> 0, 0
//    ASR: a=0 -> o,c; 0<a<W -> o>>>a, o[a-1]; a>=W -> {W{o[W-1]}}, o[W-1]
//    ROR: a=0 -> o,c; a!=0 & a mod W=0 -> o, o[W-1]; else rotr(o, a mod W), res[W-1]
//    RRX: {c, o[W-1:1]}, o[0]
//  - flush: all stage valids (and skid entry) cleared at that edge; in_ready=0 during flush; concurrent input not accepted.
//  - flush and rst dominate all; an op retiring in the flush cycle counts as retired.
//  - rst mid-operation: identical to flush plus output registers zeroed.
//  - Internal split of shifter logic across stages is free; only latency and results are specified.
// CONFIGURATION
//  `SHIFTER_SKID_EN defined: one-entry skid buffer at input; in_ready is a flop (= skid empty) with no
//   combinational path from out_ready; latency unchanged when skid empty, +1 cycle for an op that lands in skid.
//  Not defined: no skid; in_ready combinational as above; capacity exactly STAGES ops.
// TESTING
//  1. W=32: LSL o=0x80000001 a=1 c=0 -> 0x00000002, C=1, out_valid exactly STAGES cycles after accept.
//  2. LSR o=0x80000000 a=32 -> 0, C=1; a=33 -> 0, C=0; ASR a=40 -> 0xFFFFFFFF, C=1.
//  3. ROR o=0x0000000F a=4 -> 0xF0000000, C=1; ROR a=32 o=0x80000001 -> unchanged, C=1; RRX c=1 o=1 -> 0x80000000, C=1.
//  4. Stream 8 tagged ops (tags 0..7), out_ready low 10 cycles -> in_ready drops after STAGES (+1 with skid) accepts; outputs stable; tags 0..7 in order, none lost or duplicated.
//  5. flush with 2 in flight and in_valid high -> out_valid=0 next cycle; only ops accepted after flush emerge.
//  6. WIDTH=16: LSL o=0x0001 a=16 -> 0, C=1; rst asserted mid-stream -> all outputs 0 next cycle.

Source files
------------

// File: rtl/operand_shifter_pipe.sv
// operand_shifter_pipe: pipelined ARM operand-2 barrel shifter with an elastic
// valid/ready pipeline, tag pass-through and flush.
// Optional build macro: SHIFTER_SKID_EN adds a one-entry input skid buffer so
// in_ready has no combinational path from out_ready.
module operand_shifter_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_oper,
    input  logic [7:0]       in_amt,
    input  logic [1:0]       in_type,
    input  logic             in_rrx,
    input  logic             in_carry,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic             out_carry,
    output logic [TAG_W-1:0] out_tag
);

    localparam int unsigned WU = WIDTH;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_e;

    // Returns {carry_out, result}.
    function automatic logic [WIDTH:0] shift_op(
        input logic [WIDTH-1:0] o,
        input logic [7:0]       a,
        input shift_e           typ,
        input logic             rrx,
        input logic             c
    );
        logic [WIDTH-1:0] r;
        logic [WIDTH-1:0] t1;
        logic             cy;
        int unsigned      ai;
        int unsigned      am;
        ai = 32'(a);
        am = ai % WU;
        r  = o;
        cy = c;
        t1 = '0;
        if (rrx) begin
            r  = {c, o[WIDTH-1:1]};
            cy = o[0];
        end else if (ai != 0) begin
            unique case (typ)
                SH_LSL: begin
                    if (ai < WU) begin
                        r  = o << ai;
                        t1 = o >> (WU - ai);
                        cy = t1[0];
                    end else begin
                        r  = '0;
                        cy = (ai == WU) ? o[0] : 1'b0;
                    end
                end
                SH_LSR: begin
                    if (ai < WU) begin
                        r  = o >> ai;
                        t1 = o >> (ai - 1);
                        cy = t1[0];
                    end else begin
                        r  = '0;
                        cy = (ai == WU) ? o[WIDTH-1] : 1'b0;
                    end
                end
                SH_ASR: begin
                    if (ai < WU) begin
                        r  = $signed(o) >>> ai;
                        t1 = o >> (ai - 1);
                        cy = t1[0];
                    end else begin
                        r  = {WIDTH{o[WIDTH-1]}};
                        cy = o[WIDTH-1];
                    end
                end
                SH_ROR: begin
                    if (am == 0) begin
                        r  = o;
                        cy = o[WIDTH-1];
                    end else begin
                        r  = (o >> am) | (o << (WU - am));
                        cy = r[WIDTH-1];
                    end
                end
                default: ;
            endcase
        end
        return {cy, r};
    endfunction

    logic [WIDTH:0]   sh;
    logic             accept;
    logic             src_v;
    logic [WIDTH-1:0] src_r;
    logic             src_c;
    logic [TAG_W-1:0] src_t;

    logic [STAGES-1:0] v;
    logic [STAGES-1:0] load;
    logic [WIDTH-1:0]  res_a [STAGES];
    logic [STAGES-1:0] cy_a;
    logic [TAG_W-1:0]  tag_a [STAGES];

    // Whole shift evaluated before stage 0; later stages only carry the result.
    always_comb sh = shift_op(in_oper, in_amt, shift_e'(in_type), in_rrx, in_carry);

`ifdef SHIFTER_SKID_EN
    logic             skid_v;
    logic             skid_c;
    logic [WIDTH-1:0] skid_r;
    logic [TAG_W-1:0] skid_t;

    assign in_ready = !skid_v && !flush && !rst;
    assign accept   = in_valid && in_ready;
    assign src_v    = skid_v || accept;
    assign src_r    = skid_v ? skid_r : sh[WIDTH-1:0];
    assign src_c    = skid_v ? skid_c : sh[WIDTH];
    assign src_t    = skid_v ? skid_t : in_tag;

    // Skid entry: catches an accepted op that stage 0 cannot take, drains first.
    always_ff @(posedge clk) begin
        if (rst) begin
            skid_v <= 1'b0;
            skid_c <= 1'b0;
            skid_r <= '0;
            skid_t <= '0;
        end else if (flush) begin
            skid_v <= 1'b0;
        end else if (skid_v) begin
            if (load[0]) skid_v <= 1'b0;
        end else if (accept && !load[0]) begin
            skid_v <= 1'b1;
            skid_c <= sh[WIDTH];
            skid_r <= sh[WIDTH-1:0];
            skid_t <= in_tag;
        end
    end
`else
    assign in_ready = load[0] && !flush && !rst;
    assign accept   = in_valid && in_ready;
    assign src_v    = accept;
    assign src_r    = sh[WIDTH-1:0];
    assign src_c    = sh[WIDTH];
    assign src_t    = in_tag;
`endif

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             vr;
        logic             cr;
        logic [WIDTH-1:0] rr;
        logic [TAG_W-1:0] tr;
        logic             dv;
        logic             dc;
        logic [WIDTH-1:0] dr;
        logic [TAG_W-1:0] dt;

        if (k == 0) begin : g_first
            assign dv = src_v;
            assign dr = src_r;
            assign dc = src_c;
            assign dt = src_t;
        end else begin : g_next
            assign dv = v[k-1];
            assign dr = res_a[k-1];
            assign dc = cy_a[k-1];
            assign dt = tag_a[k-1];
        end

        // Stage k can load unless it and every stage after it are full with a stalled output;
        // written as a reduction to keep the ready chain free of bit-to-bit feedback.
        assign load[k] = out_ready || !(&v[STAGES-1:k]);

        // Stage register: holds while blocked, so a stalled output stays stable.
        always_ff @(posedge clk) begin
            if (rst) begin
                vr <= 1'b0;
                cr <= 1'b0;
                rr <= '0;
                tr <= '0;
            end else if (flush) begin
                vr <= 1'b0;
            end else if (load[k]) begin
                vr <= dv;
                cr <= dc;
                rr <= dr;
                tr <= dt;
            end
        end

        assign v[k]     = vr;
        assign res_a[k] = rr;
        assign cy_a[k]  = cr;
        assign tag_a[k] = tr;
    end

    assign out_valid = v[STAGES-1];
    assign out_res   = res_a[STAGES-1];
    assign out_carry = cy_a[STAGES-1];
    assign out_tag   = tag_a[STAGES-1];

endmodule
